rev_counter_sweep_ctrl: RTL and testbench

//  Direction controller for the 16-bit reversible counter. Drives the counter's S

---
 rtl/rev_counter_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rev_counter_sweep_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rev_counter_sweep_ctrl.sv
// Direction controller for a free-running reversible counter: drives S so the
// counter sweeps between latched lo/hi limits, counts reversals, flags errors.
module rev_counter_sweep_ctrl #(
  parameter int unsigned W    = 16,
  parameter int unsigned SW_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [W-1:0]    lo,
  input  logic [W-1:0]    hi,
  input  logic [SW_W-1:0] sweeps,
  input  logic [W-1:0]    cnt,
  output logic            S,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [SW_W-1:0] rev_cnt
);

  localparam int unsigned MIN_SPAN = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEEK = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            s_q, s_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [SW_W-1:0] rev_cnt_q, rev_cnt_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [SW_W-1:0] sweeps_q, sweeps_d;

  logic [W:0]      span_c;
  logic            span_bad_c;
  logic [W-1:0]    hi_m1_c;
  logic [W-1:0]    lo_p1_c;
  logic [SW_W-1:0] rev_inc_c;
  logic            hit_sweeps_c;
  logic            out_of_win_c;

  // Window decode on latched limits; span check uses one extra bit so hi<lo is caught
  always_comb begin
    span_c       = {1'b0, hi} - {1'b0, lo};
    span_bad_c   = span_c[W] || (span_c[W-1:0] < W'(MIN_SPAN));
    hi_m1_c      = hi_q - W'(1);
    lo_p1_c      = lo_q + W'(1);
    rev_inc_c    = rev_cnt_q + SW_W'(1);
    hit_sweeps_c = (sweeps_q != '0) && (rev_inc_c == sweeps_q);
    out_of_win_c = (cnt < lo_q) || (cnt > hi_q);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    done_d    = 1'b0;
    rev_cnt_d = rev_cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    sweeps_d  = sweeps_q;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            lo_d      = lo;
            hi_d      = hi;
            sweeps_d  = sweeps;
            rev_cnt_d = '0;
            state_d   = span_bad_c ? ST_ERR : ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (cnt < lo_q) begin
            s_d = 1'b1;
          end else if (cnt > hi_q) begin
            s_d = 1'b0;
          end else if (cnt < hi_m1_c) begin
            s_d     = 1'b1;
            state_d = ST_UP;
          end else begin
            s_d     = 1'b0;
            state_d = ST_DOWN;
          end
        end
        ST_UP: begin
          if (out_of_win_c) begin
            state_d = ST_ERR;
          end else if (cnt >= hi_m1_c) begin
            s_d       = 1'b0;
            rev_cnt_d = rev_inc_c;
            done_d    = hit_sweeps_c;
            state_d   = hit_sweeps_c ? ST_IDLE : ST_DOWN;
          end
        end
        ST_DOWN: begin
          if (out_of_win_c) begin
            state_d = ST_ERR;
          end else if (cnt <= lo_p1_c) begin
            s_d       = 1'b1;
            rev_cnt_d = rev_inc_c;
            done_d    = hit_sweeps_c;
            state_d   = hit_sweeps_c ? ST_IDLE : ST_UP;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_SEEK) || (state_d == ST_UP) || (state_d == ST_DOWN);
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rev_cnt_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      sweeps_q  <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rev_cnt_q <= rev_cnt_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      sweeps_q  <= sweeps_d;
    end
  end

  assign S       = s_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rev_cnt = rev_cnt_q;

endmodule

// File: tb/tb_rev_counter_sweep_ctrl.sv
// Directed bench: a behavioural up/down counter driven by S closes the loop.
module tb_rev_counter_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] lo;
  logic [15:0] hi;
  logic [7:0]  sweeps;
  logic [15:0] cnt;
  logic        S;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rev_cnt;

  logic        run;
  logic        load;
  logic [15:0] load_val;

  int total = 0;
  int bad   = 0;
  int ndone;
  int mx;
  int mn;
  bit in_win;

  rev_counter_sweep_ctrl #(.W(16), .SW_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .lo(lo), .hi(hi), .sweeps(sweeps), .cnt(cnt),
    .S(S), .busy(busy), .done(done), .err(err), .rev_cnt(rev_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: free-running up/down, with a bench-side load for forcing values
  always @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (run) cnt <= S ? cnt + 16'd1 : cnt - 16'd1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    lo = '0; hi = '0; sweeps = '0;
    run = 1'b0; load = 1'b1; load_val = 16'd0;
    step(); step();
    load = 1'b0;
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rev", 32'(rev_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: lo=4 hi=10 sweeps=4 from cnt=0
    lo = 16'd4; hi = 16'd10; sweeps = 8'd4; start = 1'b1;
    step(); start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_S_before", 32'(S), 32'd0);
    step();
    chk("t1_seek_S", 32'(S), 32'd1);
    run = 1'b1;
    ndone = 0; mx = 0; mn = 65535; in_win = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (int'(cnt) > mx) mx = int'(cnt);
      if (cnt == 16'd10) in_win = 1'b1;
      if (in_win && int'(cnt) < mn) mn = int'(cnt);
      if (done) ndone++;
      if (!busy) break;
    end
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_done_cnt", 32'(ndone), 32'd1);
    chk("t1_rev", 32'(rev_cnt), 32'd4);
    chk("t1_peak", 32'(mx), 32'd10);
    chk("t1_trough", 32'(mn), 32'd4);
    chk("t1_cnt_end", 32'(cnt), 32'd4);
    step();
    chk("t1_done_clr", 32'(done), 32'd0);

    // 2: enter from above, sweeps=2
    load = 1'b1; load_val = 16'h0100; step(); load = 1'b0;
    lo = 16'h0010; hi = 16'h0020; sweeps = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    step();
    chk("t2_seek_S", 32'(S), 32'd0);
    ndone = 0; mx = 0; mn = 65535; in_win = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (cnt <= 16'h0020) in_win = 1'b1;
      if (in_win && int'(cnt) > mx) mx = int'(cnt);
      if (in_win && int'(cnt) < mn) mn = int'(cnt);
      if (done) ndone++;
      if (!busy) break;
    end
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_done_cnt", 32'(ndone), 32'd1);
    chk("t2_rev", 32'(rev_cnt), 32'd2);
    chk("t2_peak", 32'(mx), 32'h20);
    chk("t2_trough", 32'(mn), 32'h10);

    // 3: span checks
    run = 1'b0;
    lo = 16'd5; hi = 16'd7; sweeps = 8'd1; start = 1'b1;
    step(); start = 1'b0;
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    lo = 16'd0; hi = 16'd100; start = 1'b1;
    step(); start = 1'b0;
    chk("t3_start_ign", 32'(err), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_stop_err", 32'(err), 32'd0);
    chk("t3_stop_busy", 32'(busy), 32'd0);
    lo = 16'd10; hi = 16'd2; start = 1'b1;
    step(); start = 1'b0;
    chk("t3_hi_lt_lo", 32'(err), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    lo = 16'd5; hi = 16'd8; start = 1'b1;
    step(); start = 1'b0;
    chk("t3_span3_err", 32'(err), 32'd0);
    chk("t3_span3_busy", 32'(busy), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_span3_stop", 32'(busy), 32'd0);

    // 4: full range, sweeps=0
    run = 1'b1;
    load = 1'b1; load_val = 16'hFFF0; step(); load = 1'b0;
    lo = 16'h0000; hi = 16'hFFFF; sweeps = 8'd0; start = 1'b1;
    step(); start = 1'b0;
    mx = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (int'(cnt) > mx) mx = int'(cnt);
      if (rev_cnt == 8'd1) break;
    end
    chk("t4_rev1", 32'(rev_cnt), 32'd1);
    chk("t4_peak", 32'(mx), 32'hFFFF);
    step();
    chk("t4_no_wrap_top", 32'(cnt), 32'hFFFE);
    load = 1'b1; load_val = 16'h0005; step(); load = 1'b0;
    mn = 65535;
    for (int i = 0; i < 100; i++) begin
      step();
      if (int'(cnt) < mn) mn = int'(cnt);
      if (rev_cnt == 8'd2) break;
    end
    chk("t4_rev2", 32'(rev_cnt), 32'd2);
    chk("t4_trough", 32'(mn), 32'd0);
    step();
    chk("t4_no_wrap_bot", 32'(cnt), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_stop_busy", 32'(busy), 32'd0);
    chk("t4_stop_S", 32'(S), 32'd1);
    chk("t4_stop_rev", 32'(rev_cnt), 32'd2);
    chk("t4_stop_done", 32'(done), 32'd0);

    // 5: start+stop together, then reset mid-UP
    load = 1'b1; load_val = 16'd5; step(); load = 1'b0;
    lo = 16'd4; hi = 16'd10; sweeps = 8'd0;
    start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    chk("t5_both_busy", 32'(busy), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rev_cnt == 8'd2) break;
    end
    chk("t5_up_S", 32'(S), 32'd1);
    chk("t5_up_rev", 32'(rev_cnt), 32'd2);
    rst_n = 1'b0; start = 1'b1;
    step(); rst_n = 1'b1; start = 1'b0;
    chk("t5_rst_S", 32'(S), 32'd0);
    chk("t5_rst_rev", 32'(rev_cnt), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);

    // 6: forced cnt=lo-1 while in DOWN
    load = 1'b1; load_val = 16'h0021; step(); load = 1'b0;
    lo = 16'h0010; hi = 16'h0020; sweeps = 8'd0; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("t6_down_S", 32'(S), 32'd0);
    chk("t6_down_busy", 32'(busy), 32'd1);
    load = 1'b1; load_val = 16'h000F; step(); load = 1'b0;
    chk("t6_pre_err", 32'(err), 32'd0);
    step();
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_err_busy", 32'(busy), 32'd0);
    chk("t6_err_S", 32'(S), 32'd0);
    chk("t6_err_rev", 32'(rev_cnt), 32'd0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t6_stop_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
